alarm_trigger: RTL and testbench
================================

Name: alarm_trigger

Overview:
- Upstream control stage for the alarm tone generator.
- Compares the running time-of-day against the programmed alarm time and runs the ring / snooze / stop / timeout state machine.
- Drives the tone generator's `alarm` enable and its 2-bit song select. The song select is latched when ringing starts, so a select change mid-ring cannot switch the song.

Parameters:
- SNOOZE_SEC, 300: seconds of silence after a snooze before re-ringing.
- RING_TIMEOUT_SEC, 600: seconds of unattended ringing before automatic stop.
- MAX_SNOOZES, 3: snoozes allowed per alarm event; further snooze presses act as stop.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- tick_1hz  in  1  one-cycle pulse once per second, aligned to time-of-day update.
- cur_hour  in  5  current hour, 0-23.
- cur_min  in  6  current minute, 0-59.
- alm_hour  in  5  programmed alarm hour, 0-23.
- alm_min  in  6  programmed alarm minute, 0-59.
- alarm_en  in  1  alarm armed switch (level).
- song_sel  in  2  requested song.
- snooze_p  in  1  debounced one-cycle snooze press.
- stop_p  in  1  debounced one-cycle stop press.
- alarm  out  1  tone enable to tone generator.
- sel  out  2  latched song select to tone generator.
- snoozing  out  1  high while in SNOOZE state (status LED).
- snooze_cnt  out  2  snoozes used in the current event.

Behaviour:
- All outputs registered. Reset (rst=0 at a clock edge) gives: state=IDLE, alarm=0, sel=2'b00, snoozing=0, snooze_cnt=0, all counters 0. Reset mid-ring clears alarm on that same edge.
- match = (cur_hour==alm_hour) && (cur_min==alm_min), combinational.
- States: IDLE, ARMED, RINGING, SNOOZE, HOLD.
- IDLE:
  - alarm_en=1 and match=0 -> ARMED.
  - alarm_en=1 and match=1 -> HOLD, so enabling during the alarm minute does not ring.
- ARMED:
  - match=1 -> RINGING. alarm=1 and sel=song_sel are captured on the same edge, giving 1-cycle latency from match.
  - ring_sec and snooze_cnt are cleared on this transition.
- RINGING:
  - ring_sec increments on each tick_1hz.
  - stop_p -> HOLD.
  - snooze_p with snooze_cnt<MAX_SNOOZES -> SNOOZE: snooze_cnt+1, snz_sec=0, alarm=0.
  - snooze_p with snooze_cnt==MAX_SNOOZES -> HOLD.
  - tick_1hz when ring_sec==RING_TIMEOUT_SEC-1 -> HOLD (timeout).
- SNOOZE:
  - snoozing=1, alarm=0. snz_sec increments on each tick_1hz.
  - tick_1hz when snz_sec==SNOOZE_SEC-1 -> RINGING with alarm=1, ring_sec=0, sel unchanged (not re-latched).
  - stop_p -> HOLD.
  - snooze_p is ignored.
- HOLD:
  - alarm=0, snoozing=0.
  - Leave for ARMED only when match=0. This prevents a retrigger within the alarm minute.
  - snooze_cnt holds its value until the next ARMED->RINGING transition.
- alarm_en=0 in any state -> IDLE next edge with alarm=0 and snoozing=0. This has priority over everything except reset.
- Same-cycle priority: reset > alarm_en=0 > stop_p > snooze_p > timeout tick. A snooze press and a timeout tick on the same cycle take the snooze path.
- Alarm time changed while RINGING or SNOOZE: no effect until HOLD/ARMED.
- Counter widths: ring_sec is $clog2(RING_TIMEOUT_SEC) bits; snz_sec is $clog2(SNOOZE_SEC) bits. Neither counter wraps because both are cleared on state entry.
- sel changes only on the ARMED->RINGING transition and on reset.

Decomposition:
- Shared package alarm_pkg holds:
  - the state enum (IDLE, ARMED, RINGING, SNOOZE, HOLD);
  - the song select constants SONG_0..SONG_3 (2'b00..2'b11);
  - the time field widths HOUR_W=5 and MIN_W=6.
- One natural sub-module: sec_counter, a tick_1hz-driven seconds counter with clear, enable, and terminal-count compare. Instantiate it twice, for ring_sec and snz_sec.

Test Plan (bench params SNOOZE_SEC=5, RING_TIMEOUT_SEC=8, MAX_SNOOZES=2):
- Basic ring: alarm_en=1, alm=07:30, song_sel=2'b10, drive cur 07:29->07:30 -> alarm=1 and sel=2'b10 exactly 1 cycle after cur_min=30; song_sel=2'b01 mid-ring leaves sel=2'b10.
- Timeout: ringing, no presses, 8 tick_1hz pulses -> alarm=0 after the 8th tick; stays 0 for the rest of 07:30; re-arms when cur=07:31.
- Snooze: snooze_p while ringing -> alarm=0, snoozing=1, snooze_cnt=1; after 5 ticks -> alarm=1, snoozing=0, sel unchanged.
- Snooze exhaustion: two snooze cycles (snooze_cnt=2), then a third snooze_p -> HOLD, alarm=0, snooze_cnt stays 2.
- Priority: stop_p and snooze_p in the same cycle while ringing -> HOLD, snooze_cnt unchanged. Snooze_p coincident with the 8th timeout tick -> SNOOZE.
- Reset/disable: rst=0 mid-ring -> alarm=0, sel=0 on that edge. Separately, alarm_en=0 during SNOOZE -> IDLE, snoozing=0. Re-enabling during 07:30 -> HOLD, no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger control stage.
package alarm_pkg;

  // Time-of-day field widths.
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  // Song select codes understood by the tone generator.
  localparam logic [1:0] SONG_0 = 2'b00;
  localparam logic [1:0] SONG_1 = 2'b01;
  localparam logic [1:0] SONG_2 = 2'b10;
  localparam logic [1:0] SONG_3 = 2'b11;

  // Alarm controller states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZE  = 3'd3,
    ST_HOLD    = 3'd4
  } alarm_state_t;

endpackage

// File: rtl/alarm_trigger_sec_counter.sv
// Seconds counter advanced by the 1 Hz tick. Clear wins over counting.
// term_s flags the tick that completes TERMINAL seconds.
module sec_counter #(
  parameter int TERMINAL = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic term
);

  localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0] LAST_C = W'(TERMINAL - 1);

  logic [W-1:0] cnt_r;

  // Count elapsed seconds; clear on reset or request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en && tick) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = en && tick && (cnt_r == LAST_C);

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares time of day with the alarm time and runs the
// ring / snooze / stop / timeout state machine driving the tone generator.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 600,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] alm_hour,
  input  logic [MIN_W-1:0]  alm_min,
  input  logic              alarm_en,
  input  logic [1:0]        song_sel,
  input  logic              snooze_p,
  input  logic              stop_p,
  output logic              alarm,
  output logic [1:0]        sel,
  output logic              snoozing,
  output logic [1:0]        snooze_cnt
);

  localparam logic [1:0] MAX_SNZ_C = 2'(MAX_SNOOZES);

  alarm_state_t state_r, state_nx_s;
  logic         alarm_r, alarm_nx_s;
  logic [1:0]   sel_r, sel_nx_s;
  logic         snoozing_r, snoozing_nx_s;
  logic [1:0]   snz_cnt_r, snz_cnt_nx_s;
  logic         match_s;
  logic         ring_clr_s, snz_clr_s;
  logic         ring_term_s, snz_term_s;

  assign match_s = (cur_hour == alm_hour) && (cur_min == alm_min);

  // Counters run only while the FSM stays in their state, so each entry
  // starts from zero and neither counter can wrap.
  assign ring_clr_s = !((state_r == ST_RINGING) && (state_nx_s == ST_RINGING));
  assign snz_clr_s  = !((state_r == ST_SNOOZE)  && (state_nx_s == ST_SNOOZE));

  sec_counter #(.TERMINAL(RING_TIMEOUT_SEC)) u_ring_sec (
    .clk  (clk),
    .rst  (rst),
    .clr  (ring_clr_s),
    .en   (state_r == ST_RINGING),
    .tick (tick_1hz),
    .term (ring_term_s)
  );

  sec_counter #(.TERMINAL(SNOOZE_SEC)) u_snz_sec (
    .clk  (clk),
    .rst  (rst),
    .clr  (snz_clr_s),
    .en   (state_r == ST_SNOOZE),
    .tick (tick_1hz),
    .term (snz_term_s)
  );

  // Next-state and next-output decode; disable beats every press.
  always_comb begin
    state_nx_s    = state_r;
    sel_nx_s      = sel_r;
    snz_cnt_nx_s  = snz_cnt_r;
    alarm_nx_s    = 1'b0;
    snoozing_nx_s = 1'b0;

    if (!alarm_en) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (match_s) begin
            state_nx_s = ST_HOLD;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (match_s) begin
            state_nx_s   = ST_RINGING;
            sel_nx_s     = song_sel;
            snz_cnt_nx_s = 2'd0;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_RINGING: begin
          if (stop_p) begin
            state_nx_s = ST_HOLD;
          end else if (snooze_p) begin
            if (snz_cnt_r < MAX_SNZ_C) begin
              state_nx_s   = ST_SNOOZE;
              snz_cnt_nx_s = snz_cnt_r + 2'd1;
            end else begin
              state_nx_s = ST_HOLD;
            end
          end else if (ring_term_s) begin
            state_nx_s = ST_HOLD;
          end else begin
            state_nx_s = ST_RINGING;
          end
        end
        ST_SNOOZE: begin
          if (stop_p) begin
            state_nx_s = ST_HOLD;
          end else if (snz_term_s) begin
            state_nx_s = ST_RINGING;
          end else begin
            state_nx_s = ST_SNOOZE;
          end
        end
        ST_HOLD: begin
          if (match_s) begin
            state_nx_s = ST_HOLD;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end

    if (state_nx_s == ST_RINGING) begin
      alarm_nx_s = 1'b1;
    end else begin
      alarm_nx_s = 1'b0;
    end

    if (state_nx_s == ST_SNOOZE) begin
      snoozing_nx_s = 1'b1;
    end else begin
      snoozing_nx_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      alarm_r    <= 1'b0;
      sel_r      <= SONG_0;
      snoozing_r <= 1'b0;
      snz_cnt_r  <= 2'd0;
    end else begin
      state_r    <= state_nx_s;
      alarm_r    <= alarm_nx_s;
      sel_r      <= sel_nx_s;
      snoozing_r <= snoozing_nx_s;
      snz_cnt_r  <= snz_cnt_nx_s;
    end
  end

  assign alarm      = alarm_r;
  assign sel        = sel_r;
  assign snoozing   = snoozing_r;
  assign snooze_cnt = snz_cnt_r;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed self-checking bench for alarm_trigger (short timing parameters).
module tb_alarm_trigger;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic       alarm_en;
  logic [1:0] song_sel;
  logic       snooze_p;
  logic       stop_p;
  logic       alarm;
  logic [1:0] sel;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  int check_cnt = 0;
  int err_cnt   = 0;

  alarm_trigger #(
    .SNOOZE_SEC       (5),
    .RING_TIMEOUT_SEC (8),
    .MAX_SNOOZES      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .alm_hour   (alm_hour),
    .alm_min    (alm_min),
    .alarm_en   (alarm_en),
    .song_sel   (song_sel),
    .snooze_p   (snooze_p),
    .stop_p     (stop_p),
    .alarm      (alarm),
    .sel        (sel),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic press_snooze();
    snooze_p = 1'b1;
    step();
    snooze_p = 1'b0;
  endtask

  // Leave the alarm minute and come back to start a fresh ring.
  task automatic re_ring();
    cur_min = 6'd31;
    step();
    cur_min = 6'd30;
    step();
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; snooze_p = 1'b0; stop_p = 1'b0;
    cur_hour = 5'd7; cur_min = 6'd29; alm_hour = 5'd7; alm_min = 6'd30;
    alarm_en = 1'b0; song_sel = 2'b10;
    step(); step();
    check_val("rst_alarm", alarm, 1'b0);
    check_val("rst_sel", sel, 2'b00);
    check_val("rst_snoozing", snoozing, 1'b0);
    check_val("rst_snooze_cnt", snooze_cnt, 2'd0);
    rst = 1'b1;

    // Basic ring
    alarm_en = 1'b1;
    step();                         // IDLE -> ARMED
    step();
    check_val("armed_alarm", alarm, 1'b0);
    cur_min = 6'd30;
    step();                         // ARMED -> RINGING on this edge
    check_val("ring_alarm", alarm, 1'b1);
    check_val("ring_sel", sel, 2'b10);
    song_sel = 2'b01;
    step();
    check_val("ring_sel_held", sel, 2'b10);

    // Timeout after 8 ticks
    for (int i = 0; i < 7; i++) tick();
    check_val("to_7ticks_alarm", alarm, 1'b1);
    tick();
    check_val("to_8ticks_alarm", alarm, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check_val("to_hold_alarm", alarm, 1'b0);
    cur_min = 6'd31;
    step();                         // HOLD -> ARMED
    check_val("rearm_alarm", alarm, 1'b0);
    song_sel = 2'b10;
    cur_min = 6'd30;
    step();
    check_val("rearm_ring", alarm, 1'b1);
    check_val("rearm_sel", sel, 2'b10);
    check_val("rearm_cnt", snooze_cnt, 2'd0);

    // Snooze and return
    press_snooze();
    check_val("snz1_alarm", alarm, 1'b0);
    check_val("snz1_snoozing", snoozing, 1'b1);
    check_val("snz1_cnt", snooze_cnt, 2'd1);
    press_snooze();                 // ignored in SNOOZE
    check_val("snz_ign_cnt", snooze_cnt, 2'd1);
    song_sel = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    check_val("snz_4ticks", snoozing, 1'b1);
    tick();
    check_val("snz_back_alarm", alarm, 1'b1);
    check_val("snz_back_snoozing", snoozing, 1'b0);
    check_val("snz_back_sel", sel, 2'b10);

    // Snooze exhaustion
    press_snooze();
    check_val("snz2_cnt", snooze_cnt, 2'd2);
    for (int i = 0; i < 5; i++) tick();
    check_val("snz2_back_alarm", alarm, 1'b1);
    press_snooze();
    check_val("exh_alarm", alarm, 1'b0);
    check_val("exh_snoozing", snoozing, 1'b0);
    check_val("exh_cnt", snooze_cnt, 2'd2);
    for (int i = 0; i < 6; i++) tick();
    check_val("exh_stays_off", alarm, 1'b0);

    // stop beats snooze
    re_ring();
    check_val("pri_ring", alarm, 1'b1);
    press_snooze();
    for (int i = 0; i < 5; i++) tick();
    check_val("pri_ring2", alarm, 1'b1);
    stop_p = 1'b1; snooze_p = 1'b1;
    step();
    stop_p = 1'b0; snooze_p = 1'b0;
    check_val("pri_stop_alarm", alarm, 1'b0);
    check_val("pri_stop_snoozing", snoozing, 1'b0);
    check_val("pri_stop_cnt", snooze_cnt, 2'd1);

    // snooze beats the timeout tick
    re_ring();
    for (int i = 0; i < 7; i++) tick();
    tick_1hz = 1'b1; snooze_p = 1'b1;
    step();
    tick_1hz = 1'b0; snooze_p = 1'b0;
    check_val("pri_to_snoozing", snoozing, 1'b1);
    check_val("pri_to_alarm", alarm, 1'b0);
    check_val("pri_to_cnt", snooze_cnt, 2'd1);

    // Disable during SNOOZE, re-enable in the alarm minute
    alarm_en = 1'b0;
    step();
    check_val("dis_snoozing", snoozing, 1'b0);
    check_val("dis_alarm", alarm, 1'b0);
    alarm_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_val("reen_no_ring", alarm, 1'b0);

    // Reset mid-ring
    song_sel = 2'b11;
    re_ring();
    check_val("rr_ring", alarm, 1'b1);
    check_val("rr_sel", sel, 2'b11);
    rst = 1'b0;
    step();
    check_val("rr_alarm", alarm, 1'b0);
    check_val("rr_sel0", sel, 2'b00);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
